hack_rom_loader: RTL and testbench

Streaming program loader for the Hack computer: accepts a length-prefixed stream of 16-bit instruction words over a valid/ready handshake and writes them into the instruction ROM's write port at consecutive addresses from 0. It holds the CPU in reset for the whole load and releases it once the last word is committed. It is the writer end of the ROM that the CPU fetches from, and it replaces bench-side program preloading with a synthesizable path.

---
 rtl/hack_rom_loader.sv | 152 +++++++++++++++
 tb/tb_hack_rom_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// Streaming program loader for the Hack instruction ROM: length-prefixed word stream in, ROM writes out.
// Optional trailing checksum word is enabled with `define LOADER_CHECKSUM_EN.
module hack_rom_loader #(
  parameter int unsigned ROM_DEPTH = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLen, StData, StCheck, StWfin, StDone, StErr} state_t;
`else
  typedef enum logic [2:0] {StIdle, StLen, StData, StWfin, StDone, StErr} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [15:0] len_q;
  logic        rom_we_q;
  logic [14:0] rom_addr_q;
  logic [15:0] rom_data_q;
  logic        cpu_reset_q;
  logic        done_q;
  logic        error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
`endif

  logic accept;
  logic last_word;
  logic take_start;
  logic enter_done;
  logic enter_err;

  always_comb begin
    state_d    = state_q;
    accept     = in_valid && in_ready;
    last_word  = ((cnt_q + 16'd1) == len_q);
    take_start = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLen;
          take_start = 1'b1;
        end
      end
      StLen: begin
        if (accept) begin
          if (in_data == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end else if ({16'd0, in_data} > ROM_DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StWfin;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) state_d = (in_data == sum_q) ? StDone : StErr;
      end
`endif
      // The final ROM write is on the bus this cycle; completion follows it.
      StWfin:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    enter_done = (state_d == StDone) && (state_q != StDone);
    enter_err  = (state_d == StErr) && (state_q != StErr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 16'd0;
      len_q       <= 16'd0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= 15'd0;
      rom_data_q  <= 16'd0;
      cpu_reset_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 16'd0;
`endif
    end else begin
      rom_we_q <= 1'b0;
      done_q   <= enter_done;
      if (take_start) begin
        cnt_q       <= 16'd0;
        cpu_reset_q <= 1'b1;
        error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_q       <= 16'd0;
`endif
      end
      if ((state_q == StLen) && accept) len_q <= in_data;
      if ((state_q == StData) && accept) begin
        rom_we_q   <= 1'b1;
        rom_addr_q <= cnt_q[14:0];
        rom_data_q <= in_data;
        cnt_q      <= cnt_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_q      <= sum_q + in_data;
`endif
      end
      if (enter_done) cpu_reset_q <= 1'b0;
      if (enter_err)  error_q     <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCheck);
`else
  assign in_ready = (state_q == StLen) || (state_q == StData);
`endif
  assign busy      = in_ready || (state_q == StWfin);
  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_data  = rom_data_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Scoreboard bench for hack_rom_loader: driver pushes expected writes/outcomes, monitor pops and checks.
module tb_hack_rom_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  hack_rom_loader #(.ROM_DEPTH(32768)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    bit is_err;
    bit lat_chk;
  } end_t;

  wr_t         wq[$];
  end_t        eq[$];
  logic [15:0] fixed[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_we_cyc = -10;
  logic        done_prev = 1'b0;
  logic        err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ROM write and every completion is checked against the scoreboard.
  always @(negedge clk) begin
    wr_t  w;
    end_t e;
    cyc++;
    if (rom_we) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr=%0h data=%0h", rom_addr, rom_data);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", {17'd0, rom_addr}, {17'd0, w.addr});
        chk("wr_data", {16'd0, rom_data}, {16'd0, w.data});
      end
      last_we_cyc = cyc;
    end
    if (done) begin
      chk("done_pulse", {31'd0, done_prev}, 32'd0);
      if (!done_prev) begin
        if (eq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 want none");
        end else begin
          e = eq.pop_front();
          chk("outcome_done", {31'd0, e.is_err}, 32'd0);
          chk("cpu_reset_at_done", {31'd0, cpu_reset}, 32'd0);
          if (e.lat_chk) chk("done_latency", cyc - last_we_cyc, 32'd1);
        end
      end
    end
    if (error && !err_prev) begin
      if (eq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_error: got error=1 want 0");
      end else begin
        e = eq.pop_front();
        chk("outcome_error", {31'd0, e.is_err}, 32'd1);
        chk("cpu_reset_at_error", {31'd0, cpu_reset}, 32'd1);
        chk("in_ready_in_err", {31'd0, in_ready}, 32'd0);
      end
    end
    done_prev = done;
    err_prev  = error;
  end

  task automatic drain();
    int n = 0;
    while ((wq.size() != 0 || eq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (wq.size() != 0 || eq.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d writes %0d outcomes pending want 0",
               wq.size(), eq.size());
      wq.delete();
      eq.delete();
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cpu_reset_rise", {31'd0, cpu_reset}, 32'd1);
    chk("busy_in_len", {31'd0, busy}, 32'd1);
    chk("error_cleared", {31'd0, error}, 32'd0);
  endtask

  // Offers one word after 'gap' idle cycles; a stray start is pulsed during the gap.
  task automatic send(input logic [15:0] w, input int gap);
    int n = 0;
    for (int k = 0; k < gap; k++) begin
      start   = (k == 0);
      in_data = 16'($urandom);
      @(negedge clk);
      chk("cpu_reset_stall", {31'd0, cpu_reset}, 32'd1);
    end
    start    = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got in_ready=0 want 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] n, input int gap, input bit rnd, input bit corrupt);
    logic [15:0] words[$];
    logic [15:0] sum;
    int          gaps[$];
    int          cs_gap;
    end_t        e;
    bit          is_err;
    sum = 16'd0;
    for (int i = 0; i < int'(n) && n <= 16'd32768; i++) begin
      words.push_back((i < fixed.size()) ? fixed[i] : 16'($urandom));
      sum = sum + words[i];
      gaps.push_back((i == 0) ? 0 : (rnd ? $urandom_range(gap, 0) : gap));
    end
    cs_gap = rnd ? $urandom_range(gap, 0) : gap;
    if (n > 16'd32768) begin
      is_err    = 1'b1;
      e.lat_chk = 1'b0;
    end else begin
`ifdef LOADER_CHECKSUM_EN
      is_err    = corrupt;
      e.lat_chk = (cs_gap == 0) && (n != 16'd0);
`else
      is_err    = 1'b0;
      e.lat_chk = (n != 16'd0);
`endif
    end
    e.is_err = is_err;
    eq.push_back(e);
    do_start();
    send(n, 0);
    for (int i = 0; i < words.size(); i++) begin
      wq.push_back({15'(i), words[i]});
      send(words[i], gaps[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    if (n <= 16'd32768) send(corrupt ? sum + 16'd1 : sum, cs_gap);
`endif
    drain();
    repeat (3) @(negedge clk);
    chk("cpu_reset_final", {31'd0, cpu_reset}, {31'd0, is_err});
    chk("error_final", {31'd0, error}, {31'd0, is_err});
    chk("busy_final", {31'd0, busy}, 32'd0);
    chk("in_ready_final", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_rom_we"}, {31'd0, rom_we}, 32'd0);
    chk({tag, "_rom_addr"}, {17'd0, rom_addr}, 32'd0);
    chk({tag, "_rom_data"}, {16'd0, rom_data}, 32'd0);
    chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk_all_reset("idle");

    fixed = '{16'h0000, 16'hFC10, 16'h0001};
    run_load(16'd3, 0, 1'b0, 1'b0);
    run_load(16'd3, 4, 1'b0, 1'b0);

    run_load(16'h8001, 0, 1'b0, 1'b0);
    run_load(16'd3, 0, 1'b0, 1'b0);

    // Abort a 5-word load after its second data word has been written.
    do_start();
    send(16'd5, 0);
    for (int i = 0; i < 2; i++) begin
      w = 16'($urandom);
      wq.push_back({15'(i), w});
      send(w, 0);
    end
    #2 reset = 1'b1;
    #1 chk_all_reset("midreset");
    @(negedge clk);
    reset = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    run_load(16'd3, 0, 1'b0, 1'b0);

    fixed.delete();
    run_load(16'd0, 0, 1'b0, 1'b0);

    fixed = '{16'h0003, 16'h0005};
    run_load(16'd2, 0, 1'b0, 1'b0);
    run_load(16'd2, 0, 1'b0, 1'b1);

    fixed.delete();
    for (int t = 0; t < 8; t++) begin
      run_load(16'($urandom_range(10, 1)), 3, 1'b1, 1'($urandom_range(1, 0)));
    end

    run_load(16'h8000, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
